// File: rtl/memory_packet_cache_request_generator.sv
// Converts engine MemoryPacket read/write commands into blocking CacheRequest
// transactions and turns read completions back into MemoryPacket responses.
package memory_packet_cache_pkg;
  localparam int DATA_W                = 32;
  localparam int NUM_FIELDS            = 4;
  localparam int CACHE_FRONTEND_ADDR_W = 32;
  localparam int CACHE_FRONTEND_BYTE_W = 2;
  localparam int CACHE_CTRL_CNT        = 1;
  localparam bit WORD_ADDR             = 1'b0;
  localparam int CACHE_ADDR_W          = CACHE_CTRL_CNT + CACHE_FRONTEND_ADDR_W;
  localparam int SHIFT_W               = $clog2(CACHE_FRONTEND_ADDR_W);
  localparam int ID_W                  = 8;
  localparam int BUFFER_W              = 4;

  typedef enum logic [2:0] {
    CMD_INVALID, CMD_MEM_READ, CMD_MEM_WRITE, CMD_MEM_RESPONSE, CMD_ENGINE
  } command_t;

  typedef struct packed {
    logic [ID_W-1:0] from_id;
    logic [ID_W-1:0] to_id;
  } route_t;

  typedef struct packed {
    logic               direction;
    logic [SHIFT_W-1:0] amount;
  } shift_t;

  typedef struct packed {
    logic [CACHE_FRONTEND_ADDR_W-1:0] base;
    logic [CACHE_FRONTEND_ADDR_W-1:0] offset;
    shift_t                           shift;
  } address_t;

  typedef struct packed {
    command_t            cmd;
    logic [BUFFER_W-1:0] buffer;
  } subclass_t;

  typedef struct packed {
    route_t    route;
    address_t  address;
    subclass_t subclass;
  } meta_t;

  typedef struct packed {
    logic [NUM_FIELDS-1:0][DATA_W-1:0] field;
  } data_t;

  typedef struct packed {
    logic  valid;
    meta_t meta;
    data_t data;
  } MemoryPacket;

  typedef struct packed {
    logic                    valid;
    logic [CACHE_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]       wdata;
    logic [DATA_W/8-1:0]     wstrb;
  } cache_iob_req_t;

  typedef struct packed {
    cache_iob_req_t iob;
    meta_t          meta;
    data_t          data;
  } cache_req_payload_t;

  typedef struct packed {
    logic               valid;
    cache_req_payload_t payload;
  } CacheRequest;

  typedef struct packed {
    logic              ready;
    logic [DATA_W-1:0] rdata;
  } cache_iob_resp_t;

  typedef struct packed {
    cache_iob_resp_t iob;
  } cache_resp_payload_t;

  typedef struct packed {
    cache_resp_payload_t payload;
  } CacheResponse;

  typedef struct packed {
    logic full;
    logic empty;
    logic valid;
    logic prog_full;
    logic wr_rst_busy;
    logic rd_rst_busy;
  } FIFOStateSignalsOutput;
endpackage

module memory_packet_cache_request_generator
  import memory_packet_cache_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int PROG_THRESH = 12
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  MemoryPacket           request_in,
  output FIFOStateSignalsOutput fifo_request_in_signals_out,
  output CacheRequest           request_out,
  input  CacheResponse          response_in,
  output MemoryPacket           response_out,
  input  logic                  response_out_stall,
  output logic                  busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;

  state_t             state_q, state_d;
  MemoryPacket        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q;
  logic               fifo_full, fifo_empty, push, pop;
  MemoryPacket        head_q, pkt_q;
  logic               head_vld_q;
  cache_req_payload_t req_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               load_req, capture_rdata;

  function automatic logic [CACHE_ADDR_W-1:0] effective_addr(input address_t a);
    logic [CACHE_FRONTEND_ADDR_W-1:0] sh;
    logic [CACHE_FRONTEND_ADDR_W-1:0] byte_addr;
    sh = a.shift.direction ? (a.offset << a.shift.amount) : (a.offset >> a.shift.amount);
    // Carry out of the add is discarded; control bits above the frontend range stay 0.
    byte_addr = a.base + sh;
    if (WORD_ADDR) return CACHE_ADDR_W'(byte_addr >> CACHE_FRONTEND_BYTE_W);
    return CACHE_ADDR_W'(byte_addr);
  endfunction

  function automatic cache_req_payload_t form_request(input MemoryPacket p);
    cache_req_payload_t r;
    r           = '0;
    r.iob.valid = 1'b1;
    r.iob.addr  = effective_addr(p.meta.address);
    if (p.meta.subclass.cmd == CMD_MEM_WRITE) begin
      r.iob.wstrb = '1;
      r.iob.wdata = p.data.field[0];
    end
    r.meta = p.meta;
    r.data = p.data;
    return r;
  endfunction

  assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = (state_q == IDLE) && !head_vld_q && !fifo_empty;
  // A pop in the same cycle frees a slot, so a push at full is still taken.
  assign push       = request_in.valid && (!fifo_full || pop);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: packet storage is left unreset; pointers and count guard every read.
  always_ff @(posedge ap_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= request_in;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= IDLE;
      head_vld_q <= 1'b0;
      head_q     <= '0;
      pkt_q      <= '0;
      req_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        head_q     <= fifo_mem[rd_ptr_q];
        head_vld_q <= 1'b1;
      end else if (state_q == IDLE) begin
        head_vld_q <= 1'b0;
      end
      if (load_req) begin
        pkt_q <= head_q;
        req_q <= form_request(head_q);
      end
      if (capture_rdata) rdata_q <= response_in.payload.iob.rdata;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    load_req      = 1'b0;
    capture_rdata = 1'b0;
    case (state_q)
      IDLE: begin
        // Non-memory commands are consumed here without touching the cache.
        if (head_vld_q && (head_q.meta.subclass.cmd inside {CMD_MEM_READ, CMD_MEM_WRITE})) begin
          load_req = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (response_in.payload.iob.ready) begin
          if (pkt_q.meta.subclass.cmd == CMD_MEM_READ) begin
            capture_rdata = 1'b1;
            state_d       = RESPOND;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RESPOND: begin
        if (!response_out_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    request_out  = '0;
    response_out = '0;
    if (state_q == ISSUE) begin
      request_out.valid   = 1'b1;
      request_out.payload = req_q;
    end
    if (state_q == RESPOND) begin
      response_out                    = pkt_q;
      response_out.valid              = 1'b1;
      response_out.meta.subclass.cmd  = CMD_MEM_RESPONSE;
      response_out.data.field[0]      = rdata_q;
    end
  end

  always_comb begin
    fifo_request_in_signals_out           = '0;
    fifo_request_in_signals_out.full      = fifo_full;
    fifo_request_in_signals_out.empty     = fifo_empty;
    fifo_request_in_signals_out.valid     = !fifo_empty;
    fifo_request_in_signals_out.prog_full = (count_q >= (PTR_W+1)'(PROG_THRESH));
  end

  assign busy = !fifo_empty || head_vld_q || (state_q != IDLE);
endmodule

// File: tb/tb_memory_packet_cache_request_generator.sv
// Directed bench with a scoreboard of expected cache requests and response packets,
// plus a small cache model answering request_out after a programmable latency.
module tb_memory_packet_cache_request_generator;
  import memory_packet_cache_pkg::*;

  localparam int FIFO_DEPTH  = 16;
  localparam int PROG_THRESH = 12;

  logic                  ap_clk = 1'b0;
  logic                  ap_rst_n = 1'b0;
  logic                  response_out_stall = 1'b0;
  MemoryPacket           request_in = '0;
  MemoryPacket           response_out;
  FIFOStateSignalsOutput fifo_state;
  CacheRequest           request_out;
  CacheResponse          response_in = '0;
  logic                  busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_req_seen  = 0;
  int n_resp_seen = 0;

  cache_req_payload_t exp_req[$];
  MemoryPacket        exp_resp[$];

  bit cache_hold = 1'b0;
  int cache_lat  = 0;

  always #5 ap_clk = ~ap_clk;

  memory_packet_cache_request_generator #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .PROG_THRESH(PROG_THRESH)
  ) dut (
    .ap_clk                     (ap_clk),
    .ap_rst_n                   (ap_rst_n),
    .request_in                 (request_in),
    .fifo_request_in_signals_out(fifo_state),
    .request_out                (request_out),
    .response_in                (response_in),
    .response_out               (response_out),
    .response_out_stall         (response_out_stall),
    .busy                       (busy)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] cache_rdata(input logic [CACHE_ADDR_W-1:0] a);
    return a[DATA_W-1:0] ^ 32'h0000_CEB5;
  endfunction

  function automatic FIFOStateSignalsOutput fifo_exp(input int cnt);
    FIFOStateSignalsOutput s;
    s           = '0;
    s.full      = (cnt >= FIFO_DEPTH);
    s.empty     = (cnt == 0);
    s.valid     = (cnt != 0);
    s.prog_full = (cnt >= PROG_THRESH);
    return s;
  endfunction

  function automatic MemoryPacket mk(input command_t cmd, input logic [31:0] base,
                                     input logic [31:0] offset, input logic dir,
                                     input logic [SHIFT_W-1:0] amt, input logic [DATA_W-1:0] d0);
    MemoryPacket p;
    p                             = '0;
    p.valid                       = 1'b1;
    p.meta.route.from_id          = 8'($urandom);
    p.meta.route.to_id            = 8'($urandom);
    p.meta.subclass.cmd           = cmd;
    p.meta.subclass.buffer        = 4'($urandom);
    p.meta.address.base           = base;
    p.meta.address.offset         = offset;
    p.meta.address.shift.direction = dir;
    p.meta.address.shift.amount   = amt;
    p.data.field[0]               = d0;
    for (int i = 1; i < NUM_FIELDS; i++) p.data.field[i] = $urandom;
    return p;
  endfunction

  // Drives one packet for one clock edge and records what the cache and engine should see.
  task automatic send(input MemoryPacket p, input bit accept);
    cache_req_payload_t r;
    MemoryPacket        q;
    logic [31:0]        sh;
    logic [31:0]        ba;
    if (accept && (p.meta.subclass.cmd inside {CMD_MEM_READ, CMD_MEM_WRITE})) begin
      sh = p.meta.address.shift.direction ? (p.meta.address.offset << p.meta.address.shift.amount)
                                          : (p.meta.address.offset >> p.meta.address.shift.amount);
      ba = p.meta.address.base + sh;
      r           = '0;
      r.iob.valid = 1'b1;
      r.iob.addr  = CACHE_ADDR_W'(ba);
      if (p.meta.subclass.cmd == CMD_MEM_WRITE) begin
        r.iob.wstrb = 4'hF;
        r.iob.wdata = p.data.field[0];
      end
      r.meta = p.meta;
      r.data = p.data;
      exp_req.push_back(r);
      if (p.meta.subclass.cmd == CMD_MEM_READ) begin
        q                     = p;
        q.meta.subclass.cmd   = CMD_MEM_RESPONSE;
        q.data.field[0]       = cache_rdata(CACHE_ADDR_W'(ba));
        exp_resp.push_back(q);
      end
    end
    request_in = p;
    @(posedge ap_clk);
    #1;
    request_in = '0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy && exp_req.size() == 0 && exp_resp.size() == 0) break;
      @(posedge ap_clk);
      #1;
    end
    check({tag, "_drained"}, 512'({busy, exp_req.size() != 0, exp_resp.size() != 0}), 512'(0));
  endtask

  // Cache model and request monitor.
  cache_req_payload_t held_req;
  bit in_txn   = 1'b0;
  int wait_cnt = 0;
  always @(negedge ap_clk) begin
    response_in = '0;
    if (!ap_rst_n) begin
      in_txn   = 1'b0;
      wait_cnt = 0;
    end else if (request_out.valid) begin
      if (!in_txn) begin
        in_txn   = 1'b1;
        wait_cnt = 0;
        held_req = request_out.payload;
        n_req_seen++;
        check("req_expected", 512'(exp_req.size() != 0), 512'(1));
        if (exp_req.size() != 0) check("req_payload", 512'(request_out.payload), 512'(exp_req.pop_front()));
      end else begin
        check("req_stable", 512'(request_out.payload), 512'(held_req));
      end
      if (!cache_hold && wait_cnt >= cache_lat) begin
        response_in.payload.iob.ready = 1'b1;
        response_in.payload.iob.rdata = cache_rdata(request_out.payload.iob.addr);
        in_txn = 1'b0;
      end else begin
        wait_cnt++;
      end
    end
  end

  // Response monitor: a response is consumed on a cycle with no stall.
  MemoryPacket held_resp;
  bit resp_held = 1'b0;
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      resp_held = 1'b0;
    end else if (response_out.valid) begin
      if (resp_held) check("resp_stable", 512'(response_out), 512'(held_resp));
      if (response_out_stall) begin
        held_resp = response_out;
        resp_held = 1'b1;
      end else begin
        resp_held = 1'b0;
        n_resp_seen++;
        check("resp_expected", 512'(exp_resp.size() != 0), 512'(1));
        if (exp_resp.size() != 0) check("resp_packet", 512'(response_out), 512'(exp_resp.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rq;
    int          rs;
    MemoryPacket snap;

    repeat (2) @(posedge ap_clk);
    #1;
    check("rst_request_out", 512'(request_out), 512'(0));
    check("rst_response_out", 512'(response_out), 512'(0));
    check("rst_fifo_state", 512'(fifo_state), 512'(fifo_exp(0)));
    check("rst_busy", 512'(busy), 512'(0));
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;

    // Single read, cache answers one cycle after valid.
    cache_lat = 1;
    send(mk(CMD_MEM_READ, 32'h1000, 32'h3, 1'b1, 5'd3, 32'h0), 1'b1);
    check("t1_fifo_after_push", 512'(fifo_state), 512'(fifo_exp(1)));
    @(posedge ap_clk); #1;
    check("t1_valid_edge1", 512'(request_out.valid), 512'(0));
    @(posedge ap_clk); #1;
    check("t1_valid_edge2", 512'(request_out.valid), 512'(1));
    check("t1_addr", 512'(request_out.payload.iob.addr), 512'(33'h1018));
    check("t1_wstrb", 512'(request_out.payload.iob.wstrb), 512'(0));
    wait_drain("t1", 50);

    // Cache hit in the first ISSUE cycle.
    cache_lat = 0;
    send(mk(CMD_MEM_READ, 32'h3000, 32'h8, 1'b0, 5'd1, 32'h0), 1'b1);
    @(posedge ap_clk); #1;
    @(posedge ap_clk); #1;
    check("hit_valid_edge2", 512'(request_out.valid), 512'(1));
    @(posedge ap_clk); #1;
    check("hit_resp_edge3", 512'(response_out.valid), 512'(1));
    @(posedge ap_clk); #1;
    check("hit_busy_edge4", 512'(busy), 512'(0));
    wait_drain("hit", 10);

    // Write: no response packet, busy drops after completion.
    cache_lat = 1;
    rs = n_resp_seen;
    send(mk(CMD_MEM_WRITE, 32'h2000, 32'h40, 1'b0, 5'd2, 32'h55), 1'b1);
    repeat (2) begin @(posedge ap_clk); #1; end
    check("wr_addr", 512'(request_out.payload.iob.addr), 512'(33'h2010));
    check("wr_wdata", 512'(request_out.payload.iob.wdata), 512'(32'h55));
    check("wr_wstrb", 512'(request_out.payload.iob.wstrb), 512'(4'hF));
    wait_drain("wr", 20);
    check("wr_no_response", 512'(n_resp_seen - rs), 512'(0));

    // Backpressure: one read stuck in ISSUE, then fill the FIFO to full and overflow once.
    cache_hold = 1'b1;
    cache_lat  = 0;
    rs = n_resp_seen;
    send(mk(CMD_MEM_READ, 32'h4000, 32'h0, 1'b0, 5'd0, 32'h0), 1'b1);
    repeat (3) begin @(posedge ap_clk); #1; end
    check("bp_inflight", 512'(request_out.valid), 512'(1));
    for (int i = 1; i <= FIFO_DEPTH; i++) begin
      send(mk(CMD_MEM_READ, 32'h4000 + 32'(i * 16), 32'(i), 1'b0, 5'd0, 32'(i)), 1'b1);
      check($sformatf("bp_fifo_%0d", i), 512'(fifo_state), 512'(fifo_exp(i)));
    end
    send(mk(CMD_MEM_READ, 32'h5000, 32'h0, 1'b0, 5'd0, 32'h0), 1'b0);
    check("bp_drop_full", 512'(fifo_state), 512'(fifo_exp(FIFO_DEPTH)));
    cache_hold = 1'b0;
    wait_drain("bp", 400);
    check("bp_resp_count", 512'(n_resp_seen - rs), 512'(FIFO_DEPTH + 1));

    // Response stall held for five cycles with a second read queued behind it.
    cache_lat = 1;
    response_out_stall = 1'b1;
    send(mk(CMD_MEM_READ, 32'h8000, 32'h4, 1'b1, 5'd2, 32'h0), 1'b1);
    send(mk(CMD_MEM_READ, 32'h9000, 32'h4, 1'b0, 5'd2, 32'h0), 1'b1);
    for (int i = 0; i < 30; i++) begin
      if (response_out.valid) break;
      @(posedge ap_clk); #1;
    end
    check("st_resp_valid", 512'(response_out.valid), 512'(1));
    snap = response_out;
    repeat (5) begin
      @(posedge ap_clk); #1;
      check("st_hold", 512'(response_out), 512'(snap));
      check("st_no_req", 512'(request_out.valid), 512'(0));
    end
    response_out_stall = 1'b0;
    wait_drain("st", 60);

    // Address wrap and a non-memory command that must never reach the cache.
    cache_lat = 0;
    rq = n_req_seen;
    send(mk(CMD_MEM_READ, 32'hFFFF_FFFF, 32'h1, 1'b1, 5'd0, 32'h0), 1'b1);
    send(mk(CMD_ENGINE, 32'h6000, 32'h0, 1'b0, 5'd0, 32'h0), 1'b1);
    send(mk(CMD_MEM_READ, 32'h7000, 32'h10, 1'b1, 5'd4, 32'h0), 1'b1);
    wait_drain("ovf", 60);
    check("ovf_req_count", 512'(n_req_seen - rq), 512'(2));

    // Asynchronous reset while a request is in flight with three more queued.
    cache_hold = 1'b1;
    for (int i = 0; i < 4; i++) send(mk(CMD_MEM_READ, 32'hA000 + 32'(i * 4), 32'h0, 1'b0, 5'd0, 32'h0), 1'b1);
    check("rs_inflight", 512'(request_out.valid), 512'(1));
    check("rs_fifo_3", 512'(fifo_state), 512'(fifo_exp(3)));
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("rs_request_out", 512'(request_out), 512'(0));
    check("rs_response_out", 512'(response_out), 512'(0));
    check("rs_fifo_state", 512'(fifo_state), 512'(fifo_exp(0)));
    check("rs_busy", 512'(busy), 512'(0));
    exp_req.delete();
    exp_resp.delete();
    rq = n_req_seen;
    rs = n_resp_seen;
    @(posedge ap_clk);
    #3;
    ap_rst_n   = 1'b1;
    cache_hold = 1'b0;
    repeat (30) begin @(posedge ap_clk); #1; end
    check("rs_no_req", 512'(n_req_seen - rq), 512'(0));
    check("rs_no_resp", 512'(n_resp_seen - rs), 512'(0));
    check("rs_idle", 512'(busy), 512'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
